// File: rtl/pipe_grf.sv
// ---------------------------------------------------------------------------
// pipe_grf : general register file with per-register busy (scoreboard) bits
//            for an in-order issue pipeline.
//
// Parameters
//   DATA_W  : register width
//   ADDR_W  : register index width (NREG = 2**ADDR_W)
//   SP_IDX  : index of the stack-pointer register
//   SP_INIT : reset value of reg[SP_IDX] (truncated to DATA_W)
//   BYPASS  : 1 = same-cycle write data is forwarded to the read ports
//
// Ports
//   i_clk                  : clock, all state updates on rising edge
//   i_reset                : synchronous active-high reset
//   i_raddr1/2, o_rdata1/2 : combinational read ports
//   o_busy1/2              : addressed register awaits an in-flight write
//   i_wen/i_waddr/i_wdata  : write port (also retires the busy bit)
//   i_resv_en/i_resv_addr  : reserve port (marks a register busy)
//   o_busy_cnt             : registered count of busy registers
// ---------------------------------------------------------------------------
module pipe_grf #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned SP_IDX  = 29,
    parameter logic [31:0] SP_INIT = 32'h0000_2ffc,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [ADDR_W-1:0] i_raddr1,
    input  logic [ADDR_W-1:0] i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2,
    output logic              o_busy1,
    output logic              o_busy2,
    input  logic              i_wen,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_resv_en,
    input  logic [ADDR_W-1:0] i_resv_addr,
    output logic [ADDR_W:0]   o_busy_cnt
);

    localparam int unsigned NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   r_busy;
    logic [ADDR_W:0]   r_busy_cnt;

    logic w_wr_ok;
    logic w_rv_ok;
    logic w_cnt_inc;
    logic w_cnt_dec;
    logic w_fwd1;
    logic w_fwd2;

    // Index 0 is hardwired: writes and reservations to it are dropped.
    assign w_wr_ok = i_wen     && (i_waddr     != '0);
    assign w_rv_ok = i_resv_en && (i_resv_addr != '0);

    // Count moves only on real busy-bit transitions. A write that retires a
    // register reserved again in the same cycle leaves the bit set, so it
    // must not decrement.
    assign w_cnt_inc = w_rv_ok && !r_busy[i_resv_addr];
    assign w_cnt_dec = w_wr_ok && r_busy[i_waddr] &&
                       !(w_rv_ok && (i_resv_addr == i_waddr));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;
            end
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (w_wr_ok) begin
                r_regs[i_waddr] <= i_wdata;
            end
            // Clear first, then set: reserve wins on a same-index collision.
            begin
                logic [NREG-1:0] v_busy;
                v_busy = r_busy;
                if (w_wr_ok) v_busy[i_waddr]     = 1'b0;
                if (w_rv_ok) v_busy[i_resv_addr] = 1'b1;
                r_busy <= v_busy;
            end
            case ({w_cnt_inc, w_cnt_dec})
                2'b10:   r_busy_cnt <= r_busy_cnt + (ADDR_W+1)'(1);
                2'b01:   r_busy_cnt <= r_busy_cnt - (ADDR_W+1)'(1);
                default: r_busy_cnt <= r_busy_cnt;
            endcase
        end
    end

    assign w_fwd1 = BYPASS && w_wr_ok && (i_waddr == i_raddr1);
    assign w_fwd2 = BYPASS && w_wr_ok && (i_waddr == i_raddr2);

    always_comb begin
        o_rdata1 = '0;
        o_busy1  = 1'b0;
        if (i_raddr1 != '0) begin
            o_rdata1 = w_fwd1 ? i_wdata : r_regs[i_raddr1];
            o_busy1  = w_fwd1 ? 1'b0    : r_busy[i_raddr1];
        end
    end

    always_comb begin
        o_rdata2 = '0;
        o_busy2  = 1'b0;
        if (i_raddr2 != '0) begin
            o_rdata2 = w_fwd2 ? i_wdata : r_regs[i_raddr2];
            o_busy2  = w_fwd2 ? 1'b0    : r_busy[i_raddr2];
        end
    end

    assign o_busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_pipe_grf.sv
// ---------------------------------------------------------------------------
// tb_pipe_grf : self-checking bench for pipe_grf. Two instances share all
// inputs, one with forwarding enabled and one without; both are compared
// against an array-based reference model after directed and random steps.
// ---------------------------------------------------------------------------
module tb_pipe_grf;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] raddr1, raddr2, waddr, resv_addr;
    logic [DW-1:0] wdata;
    logic          wen, resv_en;

    logic [DW-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic          bz1_b, bz2_b, bz1_n, bz2_n;
    logic [AW:0]   cnt_b, cnt_n;

    always #5 clk = ~clk;

    pipe_grf #(.DATA_W(DW), .ADDR_W(AW), .SP_IDX(29),
               .SP_INIT(32'h0000_2ffc), .BYPASS(1'b1)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_raddr1(raddr1), .i_raddr2(raddr2),
        .o_rdata1(rd1_b), .o_rdata2(rd2_b),
        .o_busy1(bz1_b), .o_busy2(bz2_b),
        .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata),
        .i_resv_en(resv_en), .i_resv_addr(resv_addr),
        .o_busy_cnt(cnt_b)
    );

    pipe_grf #(.DATA_W(DW), .ADDR_W(AW), .SP_IDX(29),
               .SP_INIT(32'h0000_2ffc), .BYPASS(1'b0)) dut_nb (
        .i_clk(clk), .i_reset(reset),
        .i_raddr1(raddr1), .i_raddr2(raddr2),
        .o_rdata1(rd1_n), .o_rdata2(rd2_n),
        .o_busy1(bz1_n), .o_busy2(bz2_n),
        .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata),
        .i_resv_en(resv_en), .i_resv_addr(resv_addr),
        .o_busy_cnt(cnt_n)
    );

    // Reference model: plain arrays of register values and busy flags.
    int unsigned m_reg  [NR];
    bit          m_busy [NR];
    bit          m_valid = 1'b0;
    int          n_assert = 0;
    int          n_fail   = 0;

    function automatic int unsigned exp_rd(int a, bit byp);
        if (a == 0) return 0;
        if (byp && wen && (int'(waddr) == a)) return wdata;
        return m_reg[a];
    endfunction

    function automatic bit exp_bz(int a, bit byp);
        if (a == 0) return 1'b0;
        if (byp && wen && (int'(waddr) == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int exp_cnt();
        int c = 0;
        for (int i = 0; i < NR; i++) c += m_busy[i];
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("rdata1_byp",  rd1_b,  exp_rd(int'(raddr1), 1'b1));
        chk("rdata2_byp",  rd2_b,  exp_rd(int'(raddr2), 1'b1));
        chk("busy1_byp",   32'(bz1_b), 32'(exp_bz(int'(raddr1), 1'b1)));
        chk("busy2_byp",   32'(bz2_b), 32'(exp_bz(int'(raddr2), 1'b1)));
        chk("rdata1_nb",   rd1_n,  exp_rd(int'(raddr1), 1'b0));
        chk("rdata2_nb",   rd2_n,  exp_rd(int'(raddr2), 1'b0));
        chk("busy1_nb",    32'(bz1_n), 32'(exp_bz(int'(raddr1), 1'b0)));
        chk("busy2_nb",    32'(bz2_n), 32'(exp_bz(int'(raddr2), 1'b0)));
        chk("busycnt_byp", 32'(cnt_b), 32'(exp_cnt()));
        chk("busycnt_nb",  32'(cnt_n), 32'(exp_cnt()));
    endtask

    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < NR; i++) begin
                m_reg[i]  = 0;
                m_busy[i] = 1'b0;
            end
            m_reg[29] = 32'h0000_2ffc;
            m_valid   = 1'b1;
        end else begin
            if (wen && waddr != 0) begin
                m_reg[waddr]  = wdata;
                m_busy[waddr] = 1'b0;
            end
            if (resv_en && resv_addr != 0) m_busy[resv_addr] = 1'b1;
        end
    endtask

    // One cycle: drive inputs, check combinational view, clock, update model.
    task automatic step(input bit rst, input bit we, input int wa, input int unsigned wd,
                        input bit rv, input int ra_rv, input int a1, input int a2);
        reset = rst; wen = we; waddr = AW'(wa); wdata = wd;
        resv_en = rv; resv_addr = AW'(ra_rv);
        raddr1 = AW'(a1); raddr2 = AW'(a2);
        #1;
        if (m_valid) check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        reset = 1'b0; wen = 1'b0; waddr = '0; wdata = '0;
        resv_en = 1'b0; resv_addr = '0; raddr1 = '0; raddr2 = '0;
        @(posedge clk); #1;

        // Reset state: SP and an ordinary register.
        step(1, 0, 0, 0, 0, 0, 29, 5);
        step(0, 0, 0, 0, 0, 0, 29, 5);

        // Same-cycle write/read of register 8, then read it back.
        step(0, 1, 8, 32'hdeadbeef, 0, 0, 8, 8);
        step(0, 0, 0, 0, 0, 0, 8, 29);

        // Index 0: write and reserve ignored.
        step(0, 1, 0, 32'h1234, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 8);

        // Reserve 3, reserve 7, write 3 <- 5.
        step(0, 0, 0, 0, 1, 3, 3, 7);
        step(0, 0, 0, 0, 1, 7, 3, 7);
        step(0, 1, 3, 5, 0, 0, 7, 1);
        step(0, 0, 0, 0, 0, 0, 3, 7);

        // Reserve 4, then reserve+write 4 together, then read it.
        step(0, 0, 0, 0, 1, 4, 4, 3);
        step(0, 1, 4, 9, 1, 4, 4, 4);
        step(0, 0, 0, 0, 0, 0, 4, 7);
        // Re-reserve a busy register; write a non-busy register.
        step(0, 1, 10, 32'h77, 1, 7, 7, 10);
        step(0, 0, 0, 0, 0, 0, 7, 10);

        // Reserve 2, 6, 9, then reset overriding a write to 6.
        step(0, 0, 0, 0, 1, 2, 2, 6);
        step(0, 0, 0, 0, 1, 6, 2, 6);
        step(0, 0, 0, 0, 1, 9, 6, 9);
        step(1, 1, 6, 32'hcafe, 1, 6, 6, 9);
        step(0, 0, 0, 0, 0, 0, 6, 29);
        step(0, 0, 0, 0, 0, 0, 2, 4);

        // Random traffic with a narrow address range to provoke collisions.
        for (int k = 0; k < 400; k++) begin
            int lim;
            int wa, rv_a, a1, a2;
            lim  = (k < 200) ? 7 : 31;
            wa   = $urandom_range(lim, 0);
            rv_a = $urandom_range(lim, 0);
            a1   = ($urandom_range(3, 0) == 0) ? wa : $urandom_range(lim, 0);
            a2   = ($urandom_range(3, 0) == 0) ? rv_a : $urandom_range(lim, 0);
            step(($urandom_range(59, 0) == 0), $urandom_range(1, 0), wa, $urandom,
                 $urandom_range(1, 0), rv_a, a1, a2);
        end
        step(0, 0, 0, 0, 0, 0, 1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_grf.md
PIPE_GRF -- requirements
Module: pipe_grf

Interface
REQ-001 SHALL expose parameter DATA_W, default 32, data width of every register.
REQ-002 SHALL expose parameter ADDR_W, default 5, register index width; register count NREG = 2**ADDR_W.
REQ-003 SHALL expose parameter SP_IDX, default 29, index of the stack-pointer register.
REQ-004 SHALL expose parameter SP_INIT, default 32'h0000_2ffc, reset value of register SP_IDX, truncated to DATA_W.
REQ-005 SHALL expose parameter BYPASS, default 1, enabling write-to-read forwarding when 1.
REQ-006 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 Reset  input  1  synchronous, active-high reset.
REQ-008 RAddr1, RAddr2  input  ADDR_W each  read-port indices.
REQ-009 RData1, RData2  output  DATA_W each  read-port data.
REQ-010 Busy1, Busy2  output  1 each  the addressed register awaits an in-flight write.
REQ-011 WEn  input  1  write enable.
REQ-012 WAddr  input  ADDR_W  write index.
REQ-013 WData  input  DATA_W  write data.
REQ-014 ResvEn  input  1  reserve request: marks a register as the destination of an issued instruction.
REQ-015 ResvAddr  input  ADDR_W  index to reserve.
REQ-016 BusyCnt  output  ADDR_W+1  number of registers currently marked busy.

Function
REQ-017 Register 0 SHALL read as 0 at all times; writes and reservations to index 0 SHALL be ignored.
REQ-018 Reads SHALL be combinational: RDataN = reg[RAddrN].
REQ-019 With BYPASS=1, WEn=1 and WAddr==RAddrN!=0, RDataN SHALL equal WData in the same cycle; with BYPASS=0, RDataN SHALL show the old value until the next edge.
REQ-020 With WEn=1 and WAddr!=0, reg[WAddr] SHALL take WData at the rising edge.
REQ-021 Each register SHALL carry one busy bit, initially 0.
REQ-022 ResvEn=1 with ResvAddr!=0 SHALL set busy[ResvAddr] at the edge.
REQ-023 WEn=1 with WAddr!=0 SHALL clear busy[WAddr] at the edge.
REQ-024 If reserve and write hit the same nonzero index in one cycle, the reserve SHALL win: data written, busy stays 1.
REQ-025 Reserving an already-busy register SHALL leave it busy; BusyCnt SHALL NOT double-count it.
REQ-026 Writing a non-busy register SHALL update data only; BusyCnt SHALL not underflow.
REQ-027 BusyN SHALL equal busy[RAddrN], except with BYPASS=1 and a same-cycle forwarding write to that index (REQ-019), where BusyN SHALL be 0.
REQ-028 Busy1, Busy2 SHALL be 0 whenever the read index is 0.
REQ-029 BusyCnt SHALL be a registered count equal to the number of set busy bits after each edge, updated as +1, -1, or 0 per cycle per REQ-022..026; range 0..NREG-1.
REQ-030 Both read ports SHALL be independent; identical addresses SHALL return identical data and busy.

Reset
REQ-031 Reset=1 at a rising edge SHALL set every register to 0 except reg[SP_IDX] = SP_INIT.
REQ-032 Reset SHALL clear all busy bits and BusyCnt to 0; it overrides same-cycle WEn and ResvEn.
REQ-033 Reset mid-operation SHALL discard all pending reservations with no deferred effect.

Verification
REQ-034 Reset, then read RAddr1=29, RAddr2=5 -> RData1=32'h2ffc, RData2=0, Busy1=Busy2=0, BusyCnt=0.
REQ-035 Write 8 <- 32'hdeadbeef with RAddr1=8 in the same cycle -> RData1=32'hdeadbeef before the edge (BYPASS=1); RData1=old value (BYPASS=0).
REQ-036 Write 0 <- 32'h1234 and reserve 0 -> RData of index 0 stays 0, Busy stays 0, BusyCnt stays 0.
REQ-037 Reserve 3, then reserve 7, then write 3 <- 5 -> BusyCnt 1, 2, 1; Busy for 3 clears; Busy for 7 stays 1.
REQ-038 With 4 busy, reserve 4 and write 4 <- 9 in the same cycle -> reg4=9, Busy for 4 = 1, BusyCnt unchanged.
REQ-039 Reserve 2, 6, 9, then assert Reset with WEn=1 for 6 -> all busy 0, BusyCnt=0, reg6=0, reg29=32'h2ffc.
